// File: rtl/alu_pkg.sv
// Shared decode definitions: ALU op codes, operand-2 select codes, RV32I opcodes,
// the decoded bundle carried by the decode stage and its skid buffer states.
// Optional feature macro used by the decoder: DECODER_ILLEGAL_FLAG_EN.
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_AND  = 4'b0010,
        ALU_OR   = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SLL  = 4'b0101,
        ALU_SRL  = 4'b0110,
        ALU_SRA  = 4'b0111,
        ALU_BEQ  = 4'b1000,
        ALU_BNE  = 4'b1001,
        ALU_SLT  = 4'b1010,
        ALU_SLTU = 4'b1011,
        ALU_BLT  = 4'b1100,
        ALU_BGE  = 4'b1101,
        ALU_NOP  = 4'b1111
    } aluop_e;

    typedef enum logic [1:0] {
        IR_RS2  = 2'b00,
        IR_IMMI = 2'b01,
        IR_IMMS = 2'b10,
        IR_ZERO = 2'b11
    } irmux_e;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    // funct7 value that turns add->sub and srl->sra
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef struct packed {
        aluop_e      aluop;
        irmux_e      irmux;
        logic [31:0] immi;
        logic [31:0] imms;
        logic [31:0] immb;
        logic [31:0] immj;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic        regwrite;
        logic        memread;
        logic        memwrite;
        logic        branch;
        logic        jal;
        logic        jalr;
        logic        illegal;
    } bundle_t;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'b00,
        BUF_ONE   = 2'b01,
        BUF_FULL  = 2'b10
    } buf_state_e;

    // Bundle presented while nothing has been decoded yet
    function automatic bundle_t reset_bundle(input bit nop);
        bundle_t b;
        b       = '0;
        b.aluop = nop ? ALU_NOP : ALU_ADD;
        b.irmux = IR_ZERO;
        return b;
    endfunction

endpackage

// File: rtl/instr_decode_comb.sv
// Purpose: pure combinational RV32I instruction -> decoded control bundle.
// Latency: zero cycles (no state).
// Backpressure: none; the caller decides when the bundle is captured.
// Macro DECODER_ILLEGAL_FLAG_EN: when defined, unsupported encodings raise illegal.
module instr_decode_comb
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] i_instr,
    output bundle_t         o_bundle
);

    logic [6:0] w_op;
    logic [2:0] w_f3;
    logic [6:0] w_f7;
    logic       w_f7_base;
    logic       w_f7_alt;
    logic       w_bad;
    bundle_t    w_b;

    assign w_op      = i_instr[6:0];
    assign w_f3      = i_instr[14:12];
    assign w_f7      = i_instr[31:25];
    assign w_f7_base = (w_f7 == F7_BASE);
    assign w_f7_alt  = (w_f7 == F7_ALT);

    // Field extraction, opcode decode, then collapse unsupported encodings to the nop bundle
    always_comb begin
        w_bad      = 1'b0;
        w_b        = '0;
        w_b.aluop  = ALU_NOP;
        w_b.irmux  = IR_ZERO;
        w_b.immi   = {{20{i_instr[31]}}, i_instr[31:20]};
        w_b.imms   = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
        w_b.immb   = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
        w_b.immj   = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};
        w_b.rs1    = i_instr[19:15];
        w_b.rs2    = i_instr[24:20];
        w_b.rd     = i_instr[11:7];
        w_b.funct3 = w_f3;

        case (w_op)
            OP_R: begin
                w_b.irmux    = IR_RS2;
                w_b.regwrite = 1'b1;
                case (w_f3)
                    3'b000: begin
                        w_b.aluop = w_f7_alt ? ALU_SUB : ALU_ADD;
                        w_bad     = !(w_f7_base || w_f7_alt);
                    end
                    3'b101: begin
                        w_b.aluop = w_f7_alt ? ALU_SRA : ALU_SRL;
                        w_bad     = !(w_f7_base || w_f7_alt);
                    end
                    3'b001:  begin w_b.aluop = ALU_SLL;  w_bad = !w_f7_base; end
                    3'b010:  begin w_b.aluop = ALU_SLT;  w_bad = !w_f7_base; end
                    3'b011:  begin w_b.aluop = ALU_SLTU; w_bad = !w_f7_base; end
                    3'b100:  begin w_b.aluop = ALU_XOR;  w_bad = !w_f7_base; end
                    3'b110:  begin w_b.aluop = ALU_OR;   w_bad = !w_f7_base; end
                    default: begin w_b.aluop = ALU_AND;  w_bad = !w_f7_base; end
                endcase
            end
            OP_IMM: begin
                w_b.irmux    = IR_IMMI;
                w_b.regwrite = 1'b1;
                case (w_f3)
                    3'b000: w_b.aluop = ALU_ADD;
                    3'b010: w_b.aluop = ALU_SLT;
                    3'b011: w_b.aluop = ALU_SLTU;
                    3'b100: w_b.aluop = ALU_XOR;
                    3'b110: w_b.aluop = ALU_OR;
                    3'b111: w_b.aluop = ALU_AND;
                    3'b001: begin
                        w_b.aluop = ALU_SLL;
                        w_bad     = !w_f7_base;
                    end
                    default: begin
                        w_b.aluop = w_f7_alt ? ALU_SRA : ALU_SRL;
                        w_bad     = !(w_f7_base || w_f7_alt);
                    end
                endcase
            end
            OP_LOAD: begin
                w_b.aluop    = ALU_ADD;
                w_b.irmux    = IR_IMMI;
                w_b.memread  = 1'b1;
                w_b.regwrite = 1'b1;
                w_bad        = !(w_f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
            end
            OP_STORE: begin
                w_b.aluop    = ALU_ADD;
                w_b.irmux    = IR_IMMS;
                w_b.memwrite = 1'b1;
                w_bad        = !(w_f3 inside {3'b000, 3'b001, 3'b010});
            end
            OP_BRANCH: begin
                w_b.irmux  = IR_RS2;
                w_b.branch = 1'b1;
                case (w_f3)
                    3'b000:  w_b.aluop = ALU_BEQ;
                    3'b001:  w_b.aluop = ALU_BNE;
                    3'b100:  w_b.aluop = ALU_BLT;
                    3'b101:  w_b.aluop = ALU_BGE;
                    default: w_bad     = 1'b1;
                endcase
            end
            OP_JAL: begin
                w_b.jal      = 1'b1;
                w_b.regwrite = 1'b1;
            end
            OP_JALR: begin
                w_b.aluop    = ALU_ADD;
                w_b.irmux    = IR_IMMI;
                w_b.jalr     = 1'b1;
                w_b.regwrite = 1'b1;
                w_bad        = (w_f3 != 3'b000);
            end
            default: w_bad = 1'b1;
        endcase

        // Anything unsupported must not write, access memory or redirect fetch
        if (w_bad) begin
            w_b.aluop    = ALU_NOP;
            w_b.irmux    = IR_ZERO;
            w_b.regwrite = 1'b0;
            w_b.memread  = 1'b0;
            w_b.memwrite = 1'b0;
            w_b.branch   = 1'b0;
            w_b.jal      = 1'b0;
            w_b.jalr     = 1'b0;
        end
`ifdef DECODER_ILLEGAL_FLAG_EN
        w_b.illegal = w_bad;
`else
        w_b.illegal = 1'b0;
`endif
    end

    assign o_bundle = w_b;

endmodule

// File: rtl/instr_decoder.sv
// Purpose: registered RV32I decode stage with a 2-entry skid buffer between fetch and execute.
// Latency: one cycle; an instruction accepted on edge N is presented after edge N.
// Backpressure: in_ready is a registered "skid not full" bit, independent of out_ready in the same cycle.
// Macro DECODER_ILLEGAL_FLAG_EN: when defined, the illegal output flags unsupported encodings.
module instr_decoder
    import alu_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter bit RESET_NOP = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] instr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [3:0]      aluop,
    output logic [1:0]      irmux,
    output logic [XLEN-1:0] immi,
    output logic [XLEN-1:0] imms,
    output logic [XLEN-1:0] immb,
    output logic [XLEN-1:0] immj,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [4:0]      rd,
    output logic [2:0]      funct3,
    output logic            regwrite,
    output logic            memread,
    output logic            memwrite,
    output logic            branch,
    output logic            jal,
    output logic            jalr,
    output logic            illegal
);

    localparam bundle_t RST_BUNDLE = reset_bundle(RESET_NOP);

    buf_state_e r_state;
    bundle_t    r_main;
    bundle_t    r_skid;
    bundle_t    w_dec;
    logic       w_in_fire;
    logic       w_out_fire;

    instr_decode_comb #(.XLEN(XLEN)) u_decode (
        .i_instr  (instr),
        .o_bundle (w_dec)
    );

    assign in_ready   = (r_state != BUF_FULL);
    assign out_valid  = (r_state != BUF_EMPTY);
    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = out_valid && out_ready;

    // Buffer occupancy and entry movement; main entry always drives the outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= BUF_EMPTY;
            r_main  <= RST_BUNDLE;
            r_skid  <= RST_BUNDLE;
        end else if (flush) begin
            r_state <= BUF_EMPTY;
        end else begin
            case (r_state)
                BUF_EMPTY: begin
                    if (w_in_fire) begin
                        r_main  <= w_dec;
                        r_state <= BUF_ONE;
                    end
                end
                BUF_ONE: begin
                    if (w_in_fire && w_out_fire) begin
                        r_main <= w_dec;
                    end else if (w_in_fire) begin
                        r_skid  <= w_dec;
                        r_state <= BUF_FULL;
                    end else if (w_out_fire) begin
                        r_state <= BUF_EMPTY;
                    end
                end
                BUF_FULL: begin
                    if (w_out_fire) begin
                        r_main  <= r_skid;
                        r_state <= BUF_ONE;
                    end
                end
                default: r_state <= BUF_EMPTY;
            endcase
        end
    end

    assign aluop    = r_main.aluop;
    assign irmux    = r_main.irmux;
    assign immi     = r_main.immi;
    assign imms     = r_main.imms;
    assign immb     = r_main.immb;
    assign immj     = r_main.immj;
    assign rs1      = r_main.rs1;
    assign rs2      = r_main.rs2;
    assign rd       = r_main.rd;
    assign funct3   = r_main.funct3;
    assign regwrite = r_main.regwrite;
    assign memread  = r_main.memread;
    assign memwrite = r_main.memwrite;
    assign branch   = r_main.branch;
    assign jal      = r_main.jal;
    assign jalr     = r_main.jalr;
    assign illegal  = r_main.illegal;

endmodule

// File: tb/tb_instr_decoder.sv
// Bench for instr_decoder: directed vectors plus randomized traffic against a
// queue-based model of a two-deep in-order stage and a table-driven RV32I decode.
module tb_instr_decoder;

`ifdef DECODER_ILLEGAL_FLAG_EN
    localparam bit FLAG_EN = 1'b1;
`else
    localparam bit FLAG_EN = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  aluop;
    logic [1:0]  irmux;
    logic [31:0] immi, imms, immb, immj;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  funct3;
    logic        regwrite, memread, memwrite, branch, jal, jalr, illegal;

    logic [158:0] got;
    logic [158:0] q[$];
    logic [158:0] rst_vec;
    int nvec = 0;
    int nerr = 0;

    instr_decoder #(.XLEN(32), .RESET_NOP(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
        .out_valid(out_valid), .out_ready(out_ready),
        .aluop(aluop), .irmux(irmux),
        .immi(immi), .imms(imms), .immb(immb), .immj(immj),
        .rs1(rs1), .rs2(rs2), .rd(rd), .funct3(funct3),
        .regwrite(regwrite), .memread(memread), .memwrite(memwrite),
        .branch(branch), .jal(jal), .jalr(jalr), .illegal(illegal)
    );

    assign got = {aluop, irmux, immi, imms, immb, immj, rs1, rs2, rd, funct3,
                  regwrite, memread, memwrite, branch, jal, jalr, illegal};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Table-driven reference decode; immediates computed with signed integer arithmetic
    function automatic logic [158:0] ref_decode(input logic [31:0] ins);
        logic [3:0] alu_by_f3 [8];
        logic [3:0] br_by_f3 [8];
        logic [6:0] opc, f7;
        logic [2:0] f3;
        logic [3:0] a;
        logic [1:0] m;
        logic rw, mr, mw, br, j, jr, legal, shift;
        int vi, vs, vb, vj;
        alu_by_f3 = '{4'h0, 4'h5, 4'hA, 4'hB, 4'h4, 4'h6, 4'h3, 4'h2};
        br_by_f3  = '{4'h8, 4'h9, 4'hF, 4'hF, 4'hC, 4'hD, 4'hF, 4'hF};
        opc = ins[6:0];
        f3  = ins[14:12];
        f7  = ins[31:25];
        vi = int'(ins[31:20]) - (ins[31] ? 4096 : 0);
        vs = int'({ins[31:25], ins[11:7]}) - (ins[31] ? 4096 : 0);
        vb = 2 * int'({ins[31], ins[7], ins[30:25], ins[11:8]}) - (ins[31] ? 8192 : 0);
        vj = 2 * int'({ins[31], ins[19:12], ins[20], ins[30:21]}) - (ins[31] ? (1 << 21) : 0);
        a = 4'hF; m = 2'b11;
        rw = 0; mr = 0; mw = 0; br = 0; j = 0; jr = 0; legal = 0;
        case (opc)
            7'b0110011: begin
                legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
                a = alu_by_f3[f3] + ((f7 == 7'h20) ? 4'd1 : 4'd0);
                m = 2'b00; rw = 1;
            end
            7'b0010011: begin
                shift = (f3 == 3'd1 || f3 == 3'd5);
                legal = !shift || (f7 == 7'h00) || (f3 == 3'd5 && f7 == 7'h20);
                a = alu_by_f3[f3] + ((f3 == 3'd5 && f7 == 7'h20) ? 4'd1 : 4'd0);
                m = 2'b01; rw = 1;
            end
            7'b0000011: begin
                legal = f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
                a = 4'h0; m = 2'b01; mr = 1; rw = 1;
            end
            7'b0100011: begin
                legal = (f3 < 3'd3);
                a = 4'h0; m = 2'b10; mw = 1;
            end
            7'b1100011: begin
                legal = (br_by_f3[f3] != 4'hF);
                a = br_by_f3[f3]; m = 2'b00; br = 1;
            end
            7'b1101111: begin
                legal = 1; a = 4'hF; m = 2'b11; j = 1; rw = 1;
            end
            7'b1100111: begin
                legal = (f3 == 3'd0);
                a = 4'h0; m = 2'b01; jr = 1; rw = 1;
            end
            default: legal = 0;
        endcase
        if (!legal) begin
            a = 4'hF; m = 2'b11;
            rw = 0; mr = 0; mw = 0; br = 0; j = 0; jr = 0;
        end
        return {a, m, 32'(vi), 32'(vs), 32'(vb), 32'(vj), ins[19:15], ins[24:20], ins[11:7], f3,
                rw, mr, mw, br, j, jr, (!legal) && FLAG_EN};
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [6:0] ops [8];
        logic [31:0] r;
        ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                7'b1100011, 7'b1101111, 7'b1100111, 7'b0000000};
        r = $urandom;
        ops[7] = 7'($urandom);
        r[6:0] = ops[$urandom_range(0, 7)];
        case ($urandom_range(0, 3))
            0: r[31:25] = 7'h00;
            1: r[31:25] = 7'h20;
            default: ;
        endcase
        return r;
    endfunction

    // Stage model: at most two decoded bundles in flight, delivered in order
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n || flush) begin
            q.delete();
        end else begin
            automatic bit fo = (q.size() > 0) && out_ready;
            automatic bit fi = in_valid && (q.size() < 2);
            if (fo) void'(q.pop_front());
            if (fi) q.push_back(ref_decode(instr));
        end
    end

    task automatic test_reset();
        rst_n = 1'b0; flush = 0; in_valid = 0; out_ready = 0; instr = '0;
        repeat (2) @(negedge clk);
        nvec++;
        if (out_valid !== 1'b0) begin nerr++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        nvec++;
        if (in_ready !== 1'b1) begin nerr++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        nvec++;
        if (got !== rst_vec) begin nerr++; $display("FAIL reset_bundle got=%h exp=%h", got, rst_vec); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [31:0] d_ins [4];
        logic [3:0]  d_alu [4];
        logic [1:0]  d_mux [4];
        logic [3:0]  d_ctl [4];  // {regwrite, memwrite, branch, illegal}
        d_ins = '{32'h00500093, 32'h40208133, 32'hFE112E23, 32'h0020E063};
        d_alu = '{4'h0, 4'h1, 4'h0, 4'hF};
        d_mux = '{2'b01, 2'b00, 2'b10, 2'b11};
        d_ctl = '{4'b1000, 4'b1000, 4'b0100, {3'b000, FLAG_EN}};
        for (int i = 0; i < 4; i++) begin
            in_valid = 1; out_ready = 1; instr = d_ins[i];
            @(negedge clk);
            in_valid = 0;
            nvec++;
            if ({out_valid, aluop, irmux, regwrite, memwrite, branch, illegal} !== {1'b1, d_alu[i], d_mux[i], d_ctl[i]}) begin
                nerr++;
                $display("FAIL directed_%0d ctl got=%b_%h_%b_%b exp=1_%h_%b_%b", i,
                         out_valid, aluop, irmux, {regwrite, memwrite, branch, illegal}, d_alu[i], d_mux[i], d_ctl[i]);
            end
            nvec++;
            if (got !== ref_decode(d_ins[i])) begin
                nerr++; $display("FAIL directed_%0d bundle got=%h exp=%h", i, got, ref_decode(d_ins[i]));
            end
            if (i == 0) begin
                nvec++;
                if ({immi, rd, rs1} !== {32'd5, 5'd1, 5'd0}) begin
                    nerr++; $display("FAIL directed_addi_fields got=%h/%0d/%0d exp=5/1/0", immi, rd, rs1);
                end
            end
            if (i == 1) begin
                nvec++;
                if ({rs1, rs2, rd} !== {5'd1, 5'd2, 5'd2}) begin
                    nerr++; $display("FAIL directed_sub_regs got=%0d/%0d/%0d exp=1/2/2", rs1, rs2, rd);
                end
            end
            if (i == 2) begin
                nvec++;
                if (imms !== 32'hFFFFFFFC) begin
                    nerr++; $display("FAIL directed_sw_imms got=%h exp=fffffffc", imms);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] a_i, b_i;
        a_i = 32'h00500093; b_i = 32'h40208133;
        out_ready = 0; in_valid = 1; instr = a_i;
        @(negedge clk);
        nvec++;
        if (in_ready !== 1'b1) begin nerr++; $display("FAIL bp_ready_after_one got=%b exp=1", in_ready); end
        instr = b_i;
        @(negedge clk);
        nvec++;
        if (in_ready !== 1'b0) begin nerr++; $display("FAIL bp_ready_full got=%b exp=0", in_ready); end
        instr = 32'hFE112E23;
        @(negedge clk);
        nvec++;
        if ({in_ready, out_valid, got} !== {2'b01, ref_decode(a_i)}) begin
            nerr++; $display("FAIL bp_hold got=%b%b %h exp=01 %h", in_ready, out_valid, got, ref_decode(a_i));
        end
        in_valid = 0; out_ready = 1;
        @(negedge clk);
        nvec++;
        if ({out_valid, got} !== {1'b1, ref_decode(b_i)}) begin
            nerr++; $display("FAIL bp_order_second got=%b %h exp=1 %h", out_valid, got, ref_decode(b_i));
        end
        @(negedge clk);
        nvec++;
        if (out_valid !== 1'b0) begin nerr++; $display("FAIL bp_third_dropped got=%b exp=0", out_valid); end
    endtask

    task automatic test_flush();
        out_ready = 0; in_valid = 1; instr = 32'h00500093;
        @(negedge clk);
        instr = 32'h40208133;
        @(negedge clk);
        nvec++;
        if (in_ready !== 1'b0) begin nerr++; $display("FAIL flush_prefill got=%b exp=0", in_ready); end
        flush = 1; instr = 32'hFE112E23;
        @(negedge clk);
        flush = 0; in_valid = 0; out_ready = 1;
        nvec++;
        if ({out_valid, in_ready} !== 2'b01) begin
            nerr++; $display("FAIL flush_empty got=%b%b exp=01", out_valid, in_ready);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            nvec++;
            if (out_valid !== 1'b0) begin nerr++; $display("FAIL flush_no_emit_%0d got=%b exp=0", i, out_valid); end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] prev;
        out_ready = 1; in_valid = 1; prev = rand_instr(); instr = prev;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            nvec++;
            if ({out_valid, in_ready, got} !== {2'b11, ref_decode(prev)}) begin
                nerr++; $display("FAIL b2b_%0d got=%b%b %h exp=11 %h", i, out_valid, in_ready, got, ref_decode(prev));
            end
            prev = rand_instr(); instr = prev;
        end
        in_valid = 0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            nvec++;
            if ({in_ready, out_valid} !== {q.size() < 2, q.size() > 0}) begin
                nerr++; $display("FAIL rand_flags_%0d got=%b%b exp=%b%b", i, in_ready, out_valid, q.size() < 2, q.size() > 0);
            end
            if (q.size() > 0) begin
                nvec++;
                if (got !== q[0]) begin nerr++; $display("FAIL rand_bundle_%0d got=%h exp=%h", i, got, q[0]); end
            end
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 24) == 0);
            instr     = rand_instr();
        end
        flush = 0; in_valid = 0; out_ready = 1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        out_ready = 0; in_valid = 1; instr = 32'h00500093;
        @(negedge clk);
        instr = 32'h0000A103;
        #2 rst_n = 1'b0;
        #1;
        nvec++;
        if ({out_valid, in_ready, aluop} !== {2'b01, 4'hF}) begin
            nerr++; $display("FAIL midreset_async got=%b%b %h exp=01 f", out_valid, in_ready, aluop);
        end
        #1 rst_n = 1'b1; in_valid = 0; out_ready = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            nvec++;
            if (out_valid !== 1'b0) begin nerr++; $display("FAIL midreset_reissue_%0d got=%b exp=0", i, out_valid); end
        end
    endtask

    initial begin
        rst_vec = {4'hF, 2'b11, 153'd0};
        test_reset();
        test_directed();
        test_backpressure();
        test_flush();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
